// File: rtl/TimerPack.sv
// TimerPack: CLINT register offsets, reset values and the byte-merge helper.
package TimerPack;
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] wdata,
                                              input logic [7:0] wmask);
    logic [63:0] res;
    res = old;
    for (int i = 0; i < 8; i++) if (wmask[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    return res;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: down-counting prescaler that pulses tick once every TICK_DIV clocks.
module tick_divider #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam logic [15:0] RELOAD = 16'(TICK_DIV - 1);
  logic [15:0] r_cnt;
  assign tick = r_cnt == 16'd0;
  always_ff @(posedge clk)
    if (rst) r_cnt <= RELOAD;
    else     r_cnt <= tick ? RELOAD : r_cnt - 16'd1;
endmodule

// File: rtl/clint_timer.sv
// clint_timer: machine timer and software interrupt unit with a single-cycle MMIO port.
module clint_timer
  import TimerPack::*;
#(
  parameter int TICK_DIV = 1,
  parameter int OFF_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [OFF_W-1:0] req_off,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wmask,
  output logic             resp_valid,
  output logic [63:0]      resp_rdata,
  output logic             resp_err,
  output logic             time_int,
  output logic             soft_int,
  output logic [63:0]      mtime_out
);
  logic             w_tick;
  logic [OFF_W-1:0] w_base;
  logic             w_sel_msip, w_sel_cmp, w_sel_time, w_hit, w_wr;
  logic [63:0]      w_rd_data, w_cmp_new, w_time_new;
  logic [63:0]      r_mtime, r_mtimecmp, r_resp_rdata;
  logic             r_msip, r_resp_valid, r_resp_err, r_time_int;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (.clk(clk), .rst(rst), .tick(w_tick));

  assign w_base     = req_off & ~OFF_W'(7);
  assign w_sel_msip = w_base == OFF_W'(MSIP_OFF);
  assign w_sel_cmp  = w_base == OFF_W'(MTIMECMP_OFF);
  assign w_sel_time = w_base == OFF_W'(MTIME_OFF);
  assign w_hit      = w_sel_msip | w_sel_cmp | w_sel_time;
  assign w_wr       = req_valid & req_we;
  assign w_cmp_new  = merge_bytes(r_mtimecmp, req_wdata, req_wmask);
  assign w_time_new = merge_bytes(r_mtime, req_wdata, req_wmask);

  always_comb
    w_rd_data = w_sel_msip ? {63'd0, r_msip} :
                w_sel_cmp  ? r_mtimecmp :
                w_sel_time ? r_mtime : 64'd0;

  // An mtime write overrides the tick increment in the same cycle.
  always_ff @(posedge clk)
    if (rst) begin
      r_mtime      <= 64'd0;
      r_mtimecmp   <= MTIMECMP_RST;
      r_msip       <= 1'b0;
      r_time_int   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= req_valid;
      if (req_valid) begin
        r_resp_rdata <= req_we ? 64'd0 : w_rd_data;
        r_resp_err   <= ~w_hit;
      end
      r_time_int <= r_mtime >= r_mtimecmp;
      if (w_wr && w_sel_msip && req_wmask[0]) r_msip <= req_wdata[0];
      if (w_wr && w_sel_cmp) r_mtimecmp <= w_cmp_new;
      r_mtime <= (w_wr && w_sel_time) ? w_time_new : r_mtime + {63'd0, w_tick};
    end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign time_int   = r_time_int;
  assign soft_int   = r_msip;
  assign mtime_out  = r_mtime;
endmodule

// File: doc/clint_timer.md
# clint_timer

Machine-mode timer and software-interrupt unit (CLINT subset) on the core's MMIO data path. Keeps a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip`, all readable and writable through a single-cycle request/response port. Drives `time_int` directly into the CSR unit, where it becomes `mip.MTIP`, and drives `soft_int` as the `mip.MSIP` source.

## Interface
Parameters:
- `TICK_DIV`, default 1: core clocks per `mtime` increment; legal range 1..65535.
- `OFF_W`, default 16: width of the register offset field.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: MMIO request present; accepted in the same cycle (no backpressure).
- `req_we`  in  1: 1 = write, 0 = read.
- `req_off`  in  `OFF_W`: byte offset inside the CLINT window; bits [2:0] are ignored.
- `req_wdata`  in  64: write data.
- `req_wmask`  in  8: byte-enable mask for writes.
- `resp_valid`  out  1: response strobe, one cycle after `req_valid`.
- `resp_rdata`  out  64: read data, or 0 for writes and errors; held until the next response.
- `resp_err`  out  1: offset was unmapped; qualified by `resp_valid`.
- `time_int`  out  1: machine timer interrupt pending, to the CSR unit's `time_int` input.
- `soft_int`  out  1: machine software interrupt pending, equal to `msip[0]`.
- `mtime_out`  out  64: current `mtime`, for cosim and trace.

## Operation
- Register map:
  - `MSIP_OFF` = 0x0000: only bit 0 is implemented; all other bits read 0.
  - `MTIMECMP_OFF` = 0x4000.
  - `MTIME_OFF` = 0xBFF8.
  - Any other offset: reads return 0 with `resp_err` = 1; writes are dropped with `resp_err` = 1.
- Writes merge byte-wise: byte i takes `req_wdata` when `req_wmask[i]` is set, otherwise keeps its old value.
- Prescaler:
  - A down-counter `div_cnt` reloads to `TICK_DIV-1`.
  - A `tick` pulse fires when `div_cnt` = 0.
  - `mtime` increments on `tick` and wraps from 2^64-1 to 0.
  - With `TICK_DIV` = 1, `tick` fires every cycle.
- Write priority: when an `mtime` write and a `tick` land in the same cycle, the write wins and there is no increment that cycle. The prescaler phase is not reset by `mtime` writes.
- Comparison is unsigned 64-bit: `time_int` is set when `mtime >= mtimecmp`. A write that raises `mtimecmp` above `mtime` clears `time_int`. `time_int` is level, never latched.
- Reads return the register value before any same-cycle update; there is no read-during-write forwarding.

## Timing
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, `div_cnt` = `TICK_DIV-1`.
  - All outputs 0: `resp_valid`, `resp_rdata`, `resp_err`, `time_int`, `soft_int`, `mtime_out`.
- Response latency is exactly 1 cycle. Back-to-back requests produce back-to-back responses, giving 1 request per cycle sustained.
- `time_int` is registered: it reflects the `mtime`/`mtimecmp` values of cycle N in cycle N+1.
- Write to cycle N changes the register in N+1 and `time_int` in N+2.
- `soft_int` follows `msip` with the same registered timing as the register itself, i.e. it is valid in N+1 after a write in N.
- Reset asserted mid-operation aborts any pending response: `resp_valid` reads 0 in the cycle after reset.
- `mtime` saturation is not applied: it wraps. When `mtimecmp` = 0, `time_int` is permanently set.

## Structure
- Shared package `TimerPack`:
  - Offset constants `MSIP_OFF`, `MTIMECMP_OFF`, `MTIME_OFF`.
  - Reset constant `MTIMECMP_RST`.
  - Function `merge_bytes(old, wdata, wmask)`.
  - Optional `timer_req_t` struct bundling `req_we`, `req_off`, `req_wdata` and `req_wmask`.
- Sub-module `tick_divider`:
  - Parameter `TICK_DIV`; ports `clk`, `rst`, output `tick`.
  - Instantiated once.
- Everything else lives in the top module: register file, address decode, response register, compare flop.

## Test plan
- Reset, then 10 cycles at `TICK_DIV` = 1 → `mtime_out` = 10, `time_int` = 0, and a read of `MTIMECMP_OFF` returns 64'hFFFF_FFFF_FFFF_FFFF with `resp_valid` exactly 1 cycle after the request.
- Write `mtimecmp` = 20 in cycle 5 → `time_int` rises in the cycle where `mtime` first equals 20, plus 1. Then write `mtimecmp` = 1000 → `time_int` falls 2 cycles after that write.
- `TICK_DIV` = 4; write `mtime` = 64'hFFFF_FFFF_FFFF_FFFE → the value wraps to 0 after 8 cycles. A write of `mtime` coinciding with `tick` leaves exactly the written value, with no increment.
- Write `mtimecmp` with `req_wdata` = 64'h1122_3344_5566_7788 and `req_wmask` = 8'h0F onto the reset value → readback is 64'hFFFF_FFFF_5566_7788.
- Write `MSIP_OFF` with 64'h3 → `soft_int` = 1 and a read returns 64'h1. Write 0 → `soft_int` = 0.
- Read and write offset 0x0100 → `resp_err` = 1 and `resp_rdata` = 0 with no state change. Assert `rst` while a read is in flight → `resp_valid` = 0 and all registers read back at their reset values.
